// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: fetch, data and memory ports of mem_port_arbiter.
// The arbiter takes the slave view; requesters and memory together form the master view.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          i_req;
  logic [AW-1:0] i_addr;
  logic [DW-1:0] i_rdata;
  logic          i_ready;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_ready;
  logic          m_req;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          m_ack;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    output i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_rdata, m_ack,
    input  i_rdata, i_ready, d_rdata, d_ready, m_req, m_we, m_addr, m_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported memory between fetch and data, one transaction at a time.
// Define ARB_STARVE_LIMIT_EN to let fetch win after STARVE_LIMIT data grants made while it waits.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
`ifdef ARB_STARVE_LIMIT_EN
  , parameter int STARVE_LIMIT = 4
`endif
) (
  input logic clock,
  input logic reset,
  mem_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;
  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          grant_d, grant_f;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q, i_rdata_q, d_rdata_q;
`ifdef ARB_STARVE_LIMIT_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve_q, starve_d;
  assign grant_f = state_q == IDLE && bus.i_req && (!bus.d_req || starve_q == CW'(STARVE_LIMIT));
  always_comb begin
    starve_d = grant_f ? '0 :
               (grant_d && bus.i_req && starve_q != CW'(STARVE_LIMIT)) ? starve_q + 1'b1 : starve_q;
  end
  always_ff @(posedge clock) begin
    starve_q <= reset ? '0 : starve_d;
  end
`else
  assign grant_f = state_q == IDLE && bus.i_req && !bus.d_req;
`endif
  assign grant_d = state_q == IDLE && bus.d_req && !grant_f;
  // owner: 0 = fetch, 1 = data
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end
  always_comb begin
    state_d = state_q == IDLE  ? ((grant_d || grant_f) ? ISSUE : IDLE) :
              state_q == ISSUE ? (bus.m_ack ? RESP : ISSUE) : IDLE;
    owner_d = (grant_d || grant_f) ? grant_d : owner_q;
  end
  always_comb begin
    bus.m_req   = state_q == ISSUE;
    bus.m_we    = m_we_q;
    bus.m_addr  = m_addr_q;
    bus.m_wdata = m_wdata_q;
    bus.i_rdata = i_rdata_q;
    bus.d_rdata = d_rdata_q;
    bus.i_ready = state_q == RESP && !owner_q;
    bus.d_ready = state_q == RESP && owner_q;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      if (grant_d || grant_f) begin
        m_addr_q <= grant_d ? bus.d_addr : bus.i_addr;
        m_we_q   <= grant_d && bus.d_we;
      end
      if (grant_d) m_wdata_q <= bus.d_wdata;
      if (state_q == ISSUE && bus.m_ack && !owner_q) i_rdata_q <= bus.m_rdata;
      if (state_q == ISSUE && bus.m_ack && owner_q && !m_we_q) d_rdata_q <= bus.m_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench with queued requesters and a wait-state memory model.
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_port_arbiter #(.AW(32), .DW(32)) dut (.clock(clk), .reset(rst), .bus(bus));
  typedef struct {
    bit          port;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } txn_t;
  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dreq_t;
  txn_t        exp_q[$];
  txn_t        cur;
  logic [31:0] f_work[$];
  dreq_t       d_work[$];
  int          req_cyc[$];
  int          n_run = 0, n_fail = 0, cyc = 0, mem_wait = 0, wcnt = 0, req_len = 0, last_len = 0;
  bit          active = 0, resp_due = 0, stray_ack = 0;
  logic [31:0] i_last = 0, d_last = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return a == 32'h40 ? 32'h2108000A : {~a[15:0], a[15:0]};
  endfunction
  task automatic want(input bit port, input bit we, input logic [31:0] a, input logic [31:0] wd);
    exp_q.push_back('{port, we, a, wd, we ? 32'h0 : mem_rd(a)});
  endtask
  task automatic fetch(input logic [31:0] a);
    f_work.push_back(a);
  endtask
  task automatic data(input bit we, input logic [31:0] a, input logic [31:0] wd);
    d_work.push_back('{we, a, wd});
  endtask
  task automatic wait_idle(input string tag);
    int n = 0;
    while ((f_work.size() != 0 || d_work.size() != 0 || exp_q.size() != 0 || active || resp_due) && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk(tag, n < 300, 1);
    repeat (2) @(negedge clk);
    #1;
  endtask
  // requesters hold their request until ready, then move to the next queued item
  initial begin
    bus.i_req = 0;
    bus.i_addr = 0;
    forever begin
      @(negedge clk);
      if (bus.i_ready && f_work.size() != 0) void'(f_work.pop_front());
      bus.i_req = f_work.size() != 0;
      if (bus.i_req) bus.i_addr = f_work[0];
    end
  end
  initial begin
    bus.d_req = 0;
    bus.d_we = 0;
    bus.d_addr = 0;
    bus.d_wdata = 0;
    forever begin
      @(negedge clk);
      if (bus.d_ready && d_work.size() != 0) void'(d_work.pop_front());
      bus.d_req = d_work.size() != 0;
      if (bus.d_req) begin
        bus.d_we = d_work[0].we;
        bus.d_addr = d_work[0].addr;
        bus.d_wdata = d_work[0].wdata;
      end
    end
  end
  initial begin
    bus.m_ack = 0;
    bus.m_rdata = 0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_ack = stray_ack;
      if (stray_ack) bus.m_rdata = 32'hBAD0BAD0;
      else if (bus.m_req) begin
        if (wcnt >= mem_wait) begin
          bus.m_ack = 1;
          bus.m_rdata = mem_rd(bus.m_addr);
          wcnt = 0;
        end else wcnt++;
      end else wcnt = 0;
    end
  end
  // monitor: grant order and request fields against the scoreboard, ready pulse one cycle after ack
  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      active = 0;
      resp_due = 0;
      i_last = 0;
      d_last = 0;
      continue;
    end
    if (resp_due) begin
      chk(cur.port ? "d_ready" : "i_ready", cur.port ? bus.d_ready : bus.i_ready, 1);
      chk("other_ready", cur.port ? bus.i_ready : bus.d_ready, 0);
      chk("m_req_resp", bus.m_req, 0);
      if (cur.port) begin
        if (!cur.we) d_last = cur.rdata;
        chk("d_rdata", bus.d_rdata, d_last);
      end else begin
        i_last = cur.rdata;
        chk("i_rdata", bus.i_rdata, i_last);
      end
      resp_due = 0;
    end else chk("idle_ready", {bus.i_ready, bus.d_ready}, 0);
    if (bus.m_req && !active) begin
      chk("req_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) cur = exp_q.pop_front();
      active = 1;
      req_len = 1;
      req_cyc.push_back(cyc);
      chk("m_addr", bus.m_addr, cur.addr);
      chk("m_we", bus.m_we, cur.we);
      if (cur.we) chk("m_wdata", bus.m_wdata, cur.wdata);
    end else if (active) begin
      req_len++;
      chk("m_req_held", bus.m_req, 1);
      chk("m_addr_stable", bus.m_addr, cur.addr);
      chk("m_we_stable", bus.m_we, cur.we);
      if (cur.we) chk("m_wdata_stable", bus.m_wdata, cur.wdata);
    end
    if (active && bus.m_ack) begin
      active = 0;
      resp_due = 1;
      last_len = req_len;
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_m_req", bus.m_req, 0);
    chk("rst_m_we", bus.m_we, 0);
    chk("rst_m_addr", bus.m_addr, 0);
    chk("rst_m_wdata", bus.m_wdata, 0);
    chk("rst_i_rdata", bus.i_rdata, 0);
    chk("rst_d_rdata", bus.d_rdata, 0);
    chk("rst_i_ready", bus.i_ready, 0);
    chk("rst_d_ready", bus.d_ready, 0);
    @(posedge clk);
    #2;
    rst = 0;
    mem_wait = 2;
    want(0, 0, 32'h40, 0);
    fetch(32'h40);
    wait_idle("t1_done");
    chk("t1_len", last_len, 3);
    mem_wait = 0;
    want(1, 0, 32'h80, 0);
    data(0, 32'h80, 0);
    wait_idle("t2_read_done");
    want(1, 1, 32'h100, 32'hDEADBEEF);
    data(1, 32'h100, 32'hDEADBEEF);
    wait_idle("t2_write_done");
    chk("t2_len", last_len, 1);
    chk("t2_d_rdata_kept", bus.d_rdata, mem_rd(32'h80));
    want(1, 0, 32'h200, 0);
    want(0, 0, 32'h204, 0);
    data(0, 32'h200, 0);
    fetch(32'h204);
    wait_idle("t3_done");
    chk("t3_gap", req_cyc[$] - req_cyc[$-1], 3);
    mem_wait = 20;
    want(1, 1, 32'h300, 32'h12345678);
    data(1, 32'h300, 32'h12345678);
    wait_idle("t6_done");
    chk("t6_len", last_len, 21);
    mem_wait = 10;
    want(1, 0, 32'h600, 0);
    data(0, 32'h600, 0);
    for (int n = 0; n < 20 && !bus.m_req; n++) @(negedge clk);
    chk("t5_req_seen", bus.m_req, 1);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    stray_ack = 1;
    f_work.delete();
    d_work.delete();
    exp_q.delete();
    @(posedge clk);
    #2;
    rst = 0;
    stray_ack = 0;
    @(negedge clk);
    chk("t5_ack_seen", bus.m_ack, 1);
    chk("t5_m_req", bus.m_req, 0);
    chk("t5_m_we", bus.m_we, 0);
    chk("t5_m_addr", bus.m_addr, 0);
    chk("t5_m_wdata", bus.m_wdata, 0);
    chk("t5_i_rdata", bus.i_rdata, 0);
    chk("t5_d_rdata", bus.d_rdata, 0);
    chk("t5_ready", {bus.i_ready, bus.d_ready}, 0);
    repeat (3) begin
      @(negedge clk);
      chk("t5_idle_m_req", bus.m_req, 0);
      chk("t5_idle_d_rdata", bus.d_rdata, 0);
    end
    mem_wait = 0;
    #1;
    for (int k = 0; k < 6; k++) data(0, 32'h400 + 4 * k, 0);
    fetch(32'h500);
`ifdef ARB_STARVE_LIMIT_EN
    for (int k = 0; k < 4; k++) want(1, 0, 32'h400 + 4 * k, 0);
    want(0, 0, 32'h500, 0);
    for (int k = 4; k < 6; k++) want(1, 0, 32'h400 + 4 * k, 0);
`else
    for (int k = 0; k < 6; k++) want(1, 0, 32'h400 + 4 * k, 0);
    want(0, 0, 32'h500, 0);
`endif
    wait_idle("t4_round1");
    for (int k = 0; k < 4; k++) data(0, 32'h700 + 4 * k, 0);
    fetch(32'h780);
    for (int k = 0; k < 4; k++) want(1, 0, 32'h700 + 4 * k, 0);
    want(0, 0, 32'h780, 0);
    wait_idle("t4_round2");
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the five-stage pipeline. It accepts one request at a time, drives a registered request/acknowledge transaction to the memory, and returns a one-cycle ready pulse with read data to the granted requester. Requesters stall their stage while their request is pending.

## Interface
- `AW`, 32: address width.
- `DW`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive data grants allowed while fetch waits. Used only with `ARB_STARVE_LIMIT_EN`.

- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `i_req` in 1: fetch read request; held until `i_ready`.
- `i_addr` in AW: fetch address; stable while `i_req`.
- `i_rdata` out DW: instruction word; valid when `i_ready`.
- `i_ready` out 1: one-cycle completion pulse to fetch.
- `d_req` in 1: data request; held until `d_ready`.
- `d_we` in 1: 1 = write, 0 = read; stable while `d_req`.
- `d_addr` in AW: data address.
- `d_wdata` in DW: write data.
- `d_rdata` out DW: load data; valid when `d_ready`.
- `d_ready` out 1: one-cycle completion pulse to memory stage.
- `m_req` out 1: memory request; held until `m_ack`.
- `m_we` out 1: memory write enable.
- `m_addr` out AW: memory address.
- `m_wdata` out DW: memory write data.
- `m_rdata` in DW: memory read data; valid with `m_ack`.
- `m_ack` in 1: one-cycle completion from memory; any number of wait cycles.

## Operation
- FSM states: IDLE, ISSUE, RESP. Tracks grantee `owner` (FETCH/DATA).
- IDLE: if `d_req` → grant DATA; else if `i_req` → grant FETCH; else stay. On grant, latch address/we/wdata into `m_*` registers, `m_req`←1, go ISSUE. Fetch grants force `m_we`=0.
- ISSUE: hold `m_req` and `m_*` stable. On `m_ack`: capture `m_rdata` into the owner's rdata register, `m_req`←0, go RESP.
- RESP: owner's ready = 1 for exactly this cycle; go IDLE. Requests are not sampled in RESP.
- Requester drops or changes its request at the edge ending RESP. A request still high in the following IDLE is a new transaction.
- `i_rdata`/`d_rdata` hold their last captured value until the next completion for that port; writes do not update `d_rdata`.
- `m_ack` seen in IDLE or RESP is ignored.
- Reset values: state IDLE, `m_req`/`m_we`/`i_ready`/`d_ready` = 0, `m_addr`/`m_wdata`/`i_rdata`/`d_rdata` = 0, starvation counter 0.
- Reset during ISSUE/RESP abandons the transaction: no ready pulse is issued and a later `m_ack` is ignored.

## Timing
- Request high in IDLE at cycle 0 → `m_req` high at cycle 1.
- `m_ack` at cycle k → ready pulse at cycle k+1, IDLE at k+2, next `m_req` no earlier than k+3.
- Minimum transaction with zero-wait memory (`m_ack` at cycle 1): 3 cycles request-to-request.
- Simultaneous `i_req` and `d_req` in IDLE: DATA wins (subject to Configuration).
- No combinational path from any input to any output.

## Configuration
- `ARB_STARVE_LIMIT_EN` undefined: strict fixed priority, DATA over FETCH. Fetch may starve indefinitely.
- `ARB_STARVE_LIMIT_EN` defined: counter increments on each DATA grant made while `i_req` is high, and clears on any FETCH grant. When the counter equals `STARVE_LIMIT` and `i_req` is high in IDLE, FETCH is granted even if `d_req` is high. Counter width is `$clog2(STARVE_LIMIT+1)` and saturates.

## Test plan
- Fetch read, addr 0x40, memory acks 2 cycles after `m_req` with 0x2108000A → `m_addr`=0x40, `m_we`=0; `i_ready` one cycle with `i_rdata`=0x2108000A; `d_ready` stays 0.
- Data write, addr 0x100, wdata 0xDEADBEEF, zero-wait ack → `m_we`=1 and `m_wdata`=0xDEADBEEF until ack; `d_ready` pulse; `d_rdata` unchanged.
- `i_req` and `d_req` both raised in the same IDLE cycle → data transaction first, `d_ready`; fetch issued next, 3 cycles after the data `m_req` with zero-wait memory.
- Continuous `d_req` with `i_req` held high, macro defined, `STARVE_LIMIT`=4 → exactly 4 data grants, then one fetch grant, counter cleared. Macro undefined → no fetch grant while `d_req` stays high.
- `reset` asserted in ISSUE, then a stray `m_ack` arrives after reset → all outputs at reset values next cycle; no ready pulse; FSM stays IDLE.
- Memory holds off ack for 20 cycles → `m_req`, `m_addr`, `m_we`, `m_wdata` stable for all 20 cycles; single ready pulse after ack.
